ghash_seq_ctrl: RTL and testbench
=================================

Name: ghash_seq_ctrl

Overview:
Sequencer that drives one streaming GHASH core for a GCM operation. It accepts AAD and text blocks and zero-masks partial final blocks. It accumulates bit lengths, appends the len(A)||len(C) length block, and returns the final GHASH value S to the tag stage. It sits between the AES-CTR/AAD block stream and the GHASH core, and owns the core's init, H, din and Y interfaces.

Parameters:
LEN_W, 64, width of each bit-length counter. Must be 64, because the length block is {aad_bits[63:0], txt_bits[63:0]}.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin an operation; honoured only in IDLE
abort  in  1  cancel the current operation; honoured in any non-IDLE state
H  in  128  hash subkey; sampled on start
blk_valid  in  1  input block valid
blk_ready  out  1  input block accepted when valid&ready
blk_data  in  128  block; byte 0 = bits [127:120]
blk_bytes  in  5  valid bytes, 0..16; 0 legal only with blk_last
blk_is_aad  in  1  1 = AAD block, 0 = text block
blk_last  in  1  final block of the whole message (AAD+text)
g_init  out  1  to core init
g_H  out  128  to core H
g_valid  out  1  to core din_valid
g_ready  in  1  from core din_ready
g_data  out  128  to core din_data
g_last  out  1  to core din_last
g_Y  in  128  from core Y
g_Y_valid  in  1  from core Y_valid
s_valid  out  1  result valid; held until s_ready
s_ready  in  1  result consumer ready
s_data  out  128  GHASH result S
busy  out  1  high in every state except IDLE
err  out  1  sticky order-violation flag; cleared on start

Behaviour:
- All registers update on posedge clk. When rst_n=0 at an edge: state=IDLE and every output/register is 0 (s_data, g_H, counters, err included).
- States: IDLE, INIT, DATA, LEN, WAIT, DONE.
- IDLE:
  - blk_ready=0, g_valid=0.
  - On start: latch H into g_H, clear aad_bits/txt_bits/seen_txt/err, go to INIT.
- INIT:
  - g_init=1 for exactly one cycle, then go to DATA.
  - g_H is held stable from INIT until the next start.
- DATA, forwarding:
  - blk_ready = g_ready; g_valid = blk_valid & (blk_bytes!=0).
  - g_data = blk_data with bytes at index >= blk_bytes forced to 0.
  - g_last=0 always; only the length block carries last.
  - A blk_bytes=0 block (with blk_last=1) is accepted with blk_ready=1 regardless of g_ready and is not forwarded.
- DATA, on each accepted block:
  - Add blk_bytes*8 to aad_bits if blk_is_aad, else to txt_bits. Counters wrap modulo 2^64; no overflow check.
  - A text block sets seen_txt.
  - An AAD block arriving while seen_txt=1 sets err and is still hashed and counted. The operation completes normally.
  - If blk_last, go to LEN.
  - A block with blk_bytes<16 but not blk_last is hashed as masked; no error.
- LEN:
  - g_valid=1, g_data={aad_bits,txt_bits}, g_last=1.
  - On g_valid&g_ready, go to WAIT.
- WAIT: on g_Y_valid, capture s_data=g_Y and go to DONE.
- DONE:
  - s_valid=1, s_data stable.
  - On s_ready, return to IDLE; s_valid drops the next cycle.
  - start is ignored until IDLE.
- abort in INIT/DATA/LEN/WAIT/DONE:
  - Next state is IDLE, with g_init=1 for that one transition cycle (combinational on abort) to flush the core.
  - Any in-flight g_Y_valid is ignored; s_valid is never asserted for the aborted operation.
  - abort in IDLE has no effect. abort has priority over start and over every state transition.
- Simultaneous events:
  - blk handshake and abort in the same cycle: the block is not counted.
  - rst_n=0 mid-operation: immediate return to IDLE at that edge, with no g_init pulse (the core is reset by the shared reset).
- Latency:
  - start to first g_valid opportunity: 2 cycles.
  - LEN acceptance to s_valid: core multiply latency + 1 cycle.

Test Plan:
- H=0x66e94bd4ef8a2c3b884cfa59ca342b2e, one text block 0x0388dace60b6a392f328c2b971b2fe78, bytes=16, last=1.
  - Expect length block 0x...0000_0080, then s_data=0xf38cbb1ad69223dcc3457ae5b6b0f885, err=0.
- Empty message: start, then a single block with bytes=0, last=1.
  - Expect exactly one core transfer (length block = 0) and s_data=0.
- Partial masking: text block bytes=4 with data 0xAABBCCDD_FFFF…FF, then the same with the low 12 bytes already 0.
  - Expect identical s_data; txt_bits=32 in the length block.
- Order violation: text block then AAD block (last=1).
  - Expect err=1, s_valid still asserted, aad_bits=128, txt_bits=128.
- Backpressure/abort:
  - Hold g_ready=0 for 5 cycles in DATA: blk_ready stays 0 and no count changes.
  - Assert abort in WAIT: one g_init pulse, state IDLE, s_valid never rises.
- Result hold: s_ready=0 for 10 cycles in DONE.
  - Expect s_valid/s_data stable and start ignored; return to IDLE after s_ready=1.

Source files
------------

// File: rtl/ghash_seq_ctrl.sv
// Sequencer for one streaming GHASH core in a GCM operation: forwards zero-masked
// AAD/text blocks, counts bit lengths, appends len(A)||len(C) and returns S.
module ghash_seq_ctrl #(
   parameter int LEN_W = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic [127:0]   H,
   input  logic           blk_valid,
   output logic           blk_ready,
   input  logic [127:0]   blk_data,
   input  logic [4:0]     blk_bytes,
   input  logic           blk_is_aad,
   input  logic           blk_last,
   output logic           g_init,
   output logic [127:0]   g_H,
   output logic           g_valid,
   input  logic           g_ready,
   output logic [127:0]   g_data,
   output logic           g_last,
   input  logic [127:0]   g_Y,
   input  logic           g_Y_valid,
   output logic           s_valid,
   input  logic           s_ready,
   output logic [127:0]   s_data,
   output logic           busy,
   output logic           err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_DATA = 3'd2,
      S_LEN  = 3'd3,
      S_WAIT = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [127:0]       g_h_q, g_h_d;
   logic [LEN_W-1:0]   aad_bits_q, aad_bits_d;
   logic [LEN_W-1:0]   txt_bits_q, txt_bits_d;
   logic               seen_txt_q, seen_txt_d;
   logic               err_q, err_d;
   logic [127:0]       s_data_q, s_data_d;

   logic               blk_ready_s;
   logic               g_valid_s;
   logic [127:0]       g_data_s;
   logic               g_last_s;
   logic               g_init_s;
   logic               abort_s;
   logic               hs_s;
   logic [LEN_W-1:0]   add_bits_s;

   // Byte 0 sits in the top byte; bytes at index >= n are forced to zero.
   function automatic logic [127:0] mask_block(input logic [127:0] d, input logic [4:0] n);
      logic [127:0] m;
      m = 128'd0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < n) begin
            m[127-8*i -: 8] = d[127-8*i -: 8];
         end else begin
            m[127-8*i -: 8] = 8'd0;
         end
      end
      return m;
   endfunction

   // Core-facing and block-facing handshake outputs, decoded from the current state.
   always_comb begin
      blk_ready_s = 1'b0;
      g_valid_s   = 1'b0;
      g_data_s    = 128'd0;
      g_last_s    = 1'b0;
      case (state_q)
         S_DATA: begin
            // Empty final blocks never reach the core, so they must not wait on it.
            blk_ready_s = (blk_bytes == 5'd0) ? 1'b1 : g_ready;
            g_valid_s   = blk_valid & (blk_bytes != 5'd0);
            g_data_s    = mask_block(blk_data, blk_bytes);
         end
         S_LEN: begin
            g_valid_s = 1'b1;
            g_data_s  = {aad_bits_q, txt_bits_q};
            g_last_s  = 1'b1;
         end
         default: begin
            blk_ready_s = 1'b0;
         end
      endcase
   end

   // Next-state and register update logic; abort overrides every transition.
   always_comb begin
      state_d    = state_q;
      g_h_d      = g_h_q;
      aad_bits_d = aad_bits_q;
      txt_bits_d = txt_bits_q;
      seen_txt_d = seen_txt_q;
      err_d      = err_q;
      s_data_d   = s_data_q;
      g_init_s   = 1'b0;
      abort_s    = abort & (state_q != S_IDLE);
      hs_s       = blk_valid & blk_ready_s;
      add_bits_s = LEN_W'({blk_bytes, 3'b000});
      if (abort_s) begin
         state_d  = S_IDLE;
         g_init_s = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_INIT;
                  g_h_d      = H;
                  aad_bits_d = {LEN_W{1'b0}};
                  txt_bits_d = {LEN_W{1'b0}};
                  seen_txt_d = 1'b0;
                  err_d      = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_INIT: begin
               g_init_s = 1'b1;
               state_d  = S_DATA;
            end
            S_DATA: begin
               if (hs_s) begin
                  // AAD after text is still hashed and counted; only the flag records it.
                  if (blk_is_aad) begin
                     aad_bits_d = aad_bits_q + add_bits_s;
                     err_d      = err_q | seen_txt_q;
                  end else begin
                     txt_bits_d = txt_bits_q + add_bits_s;
                     seen_txt_d = 1'b1;
                  end
                  if (blk_last) begin
                     state_d = S_LEN;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_DATA;
               end
            end
            S_LEN: begin
               if (g_ready) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_LEN;
               end
            end
            S_WAIT: begin
               if (g_Y_valid) begin
                  s_data_d = g_Y;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DONE: begin
               if (s_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         g_h_q      <= 128'd0;
         aad_bits_q <= {LEN_W{1'b0}};
         txt_bits_q <= {LEN_W{1'b0}};
         seen_txt_q <= 1'b0;
         err_q      <= 1'b0;
         s_data_q   <= 128'd0;
      end else begin
         state_q    <= state_d;
         g_h_q      <= g_h_d;
         aad_bits_q <= aad_bits_d;
         txt_bits_q <= txt_bits_d;
         seen_txt_q <= seen_txt_d;
         err_q      <= err_d;
         s_data_q   <= s_data_d;
      end
   end

   assign blk_ready = blk_ready_s;
   assign g_valid   = g_valid_s;
   assign g_data    = g_data_s;
   assign g_last    = g_last_s;
   assign g_init    = g_init_s;
   assign g_H       = g_h_q;
   assign s_valid   = (state_q == S_DONE);
   assign s_data    = s_data_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_ghash_seq_ctrl.sv
// Bench for ghash_seq_ctrl: a behavioural GHASH core plus a reference model that
// derives expected core transfers and S from GCM rules over directed and random messages.
module tb_ghash_seq_ctrl;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst_n, start, abort, blk_valid, blk_is_aad, blk_last;
   logic [127:0] H, blk_data;
   logic [4:0]   blk_bytes;
   logic         blk_ready, g_init, g_valid, g_last, s_valid, busy, err;
   logic [127:0] g_H, g_data, s_data;
   logic         g_ready, g_Y_valid, s_ready;
   logic [127:0] g_Y;

   int n_chk = 0;
   int n_fail = 0;

   logic [127:0] xfers[$];
   logic         xlast[$];
   logic [127:0] exp_q[$];
   logic [63:0]  ref_aad, ref_txt;
   logic         ref_seen, ref_err;
   logic [127:0] ref_h;
   logic [127:0] core_acc;
   int           core_cnt;

   always #5 clk = ~clk;

   ghash_seq_ctrl #(.LEN_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .H(H),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_bytes(blk_bytes), .blk_is_aad(blk_is_aad), .blk_last(blk_last),
      .g_init(g_init), .g_H(g_H), .g_valid(g_valid), .g_ready(g_ready),
      .g_data(g_data), .g_last(g_last), .g_Y(g_Y), .g_Y_valid(g_Y_valid),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy), .err(err)
   );

   // GF(2^128) multiply in GCM bit order.
   function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
      logic [127:0] z, v;
      z = 128'd0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   function automatic logic [127:0] ghash_ref();
      logic [127:0] y;
      y = 128'd0;
      foreach (exp_q[i]) y = gf_mul(y ^ exp_q[i], ref_h);
      return y;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Behavioural core: in-flight result is not cancelled by init, so aborts see a stray Y_valid.
   always @(posedge clk) begin
      if (!rst_n) begin
         core_acc = 128'd0;
         core_cnt = 0;
      end else begin
         if (core_cnt != 0) core_cnt = core_cnt - 1;
         if (g_init) begin
            core_acc = 128'd0;
         end else if (g_valid && g_ready) begin
            xfers.push_back(g_data);
            xlast.push_back(g_last);
            core_acc = gf_mul(core_acc ^ g_data, g_H);
            if (g_last) core_cnt = LAT;
         end
      end
   end

   always @(negedge clk) begin
      g_Y_valid = (core_cnt == 1);
      g_Y       = core_acc;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [127:0] h);
      @(negedge clk);
      xfers.delete(); xlast.delete(); exp_q.delete();
      ref_aad = 64'd0; ref_txt = 64'd0; ref_seen = 1'b0; ref_err = 1'b0; ref_h = h;
      H = h; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("init_pulse", g_init, 1'b1);
      chk("init_gH", g_H, h);
      chk("init_busy", busy, 1'b1);
   endtask

   task automatic send_block(input logic [127:0] d, input logic [4:0] nb, input logic aad,
                             input logic last, input logic bp);
      int cyc;
      logic acc;
      logic [63:0] bits;
      @(negedge clk);
      blk_data = d; blk_bytes = nb; blk_is_aad = aad; blk_last = last; blk_valid = 1'b1;
      acc = 1'b0; cyc = 0;
      while (!acc && cyc < 100) begin
         g_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         acc = blk_ready;
         @(posedge clk);
         cyc++;
         if (!acc) @(negedge clk);
      end
      chk("blk_accept", acc, 1'b1);
      if (acc) begin
         if (nb != 5'd0) exp_q.push_back(d & ~({128{1'b1}} >> (8 * nb)));
         bits = 64'(nb) * 64'd8;
         if (aad) begin
            ref_aad += bits;
            if (ref_seen) ref_err = 1'b1;
         end else begin
            ref_txt += bits;
            ref_seen = 1'b1;
         end
         if (last) exp_q.push_back({ref_aad, ref_txt});
      end
   endtask

   task automatic finish_op(input int hold, output logic [127:0] s_out);
      int cyc;
      logic got, stable;
      logic [127:0] s0;
      @(negedge clk);
      blk_valid = 1'b0; blk_last = 1'b0;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 200) begin
         g_ready = 1'($urandom_range(0, 1));
         #1;
         got = s_valid;
         if (!got) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
         end
      end
      chk("s_valid_seen", got, 1'b1);
      chk("s_data", s_data, ghash_ref());
      chk("err", err, ref_err);
      chk("xfer_count", xfers.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < xfers.size()) begin
            chk("xfer_data", xfers[i], exp_q[i]);
            chk("xfer_last", xlast[i], (i == exp_q.size() - 1));
         end
      end
      s_out = s_data;
      if (hold > 0) begin
         stable = 1'b1;
         s0 = s_data;
         for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
            if (!(s_valid === 1'b1 && s_data === s0 && g_init === 1'b0 && busy === 1'b1)) stable = 1'b0;
         end
         start = 1'b0;
         chk("hold_stable", stable, 1'b1);
      end
      s_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_ready = 1'b0;
      #1;
      chk("idle_after", busy, 1'b0);
      chk("s_valid_drop", s_valid, 1'b0);
   endtask

   initial begin
      logic [127:0] s1, s2, st;
      logic sv_seen, yv_seen;
      int nblk, na;
      logic [4:0] nb;
      logic aad;

      rst_n = 1'b0; start = 1'b1; abort = 1'b0; H = 128'hffff; blk_valid = 1'b0;
      blk_data = 128'd0; blk_bytes = 5'd0; blk_is_aad = 1'b0; blk_last = 1'b0;
      g_ready = 1'b1; s_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_s_valid", s_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_s_data", s_data, 128'd0);
      chk("rst_gH", g_H, 128'd0);
      chk("rst_blk_ready", blk_ready, 1'b0);
      chk("rst_g_valid", g_valid, 1'b0);
      chk("rst_g_init", g_init, 1'b0);
      start = 1'b0; rst_n = 1'b1;

      // Known-answer: one full text block.
      start_op(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      send_block(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b0, 1'b1, 1'b0);
      finish_op(0, s1);
      chk("kat_s", s1, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
      if (xfers.size() == 2) chk("kat_len", xfers[1], 128'h80);
      chk("kat_err", err, 1'b0);

      // Empty message: only the zero length block reaches the core.
      start_op(rnd128());
      send_block(rnd128(), 5'd0, 1'b0, 1'b1, 1'b1);
      finish_op(0, s1);
      chk("empty_count", xfers.size(), 1);
      if (xfers.size() == 1) chk("empty_len", xfers[0], 128'd0);
      chk("empty_s", s1, 128'd0);

      // Partial masking: unmasked tail bytes must not influence S.
      start_op(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      send_block(128'hAABBCCDD_FFFFFFFF_FFFFFFFF_FFFFFFFF, 5'd4, 1'b0, 1'b1, 1'b1);
      finish_op(0, s1);
      start_op(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      send_block(128'hAABBCCDD_00000000_00000000_00000000, 5'd4, 1'b0, 1'b1, 1'b1);
      finish_op(0, s2);
      chk("mask_same_s", s1, s2);
      if (xfers.size() == 2) chk("mask_len", xfers[1], 128'h20);

      // Order violation: text then AAD.
      start_op(rnd128());
      send_block(rnd128(), 5'd16, 1'b0, 1'b0, 1'b0);
      send_block(rnd128(), 5'd16, 1'b1, 1'b1, 1'b0);
      finish_op(0, s1);
      chk("order_err", err, 1'b1);
      if (xfers.size() == 3) chk("order_len", xfers[2], {64'd128, 64'd128});

      // Backpressure in DATA: nothing accepted while the core stalls.
      start_op(rnd128());
      st = rnd128();
      @(negedge clk);
      blk_data = st; blk_bytes = 5'd16; blk_is_aad = 1'b0; blk_last = 1'b1; blk_valid = 1'b1;
      g_ready = 1'b0;
      sv_seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         sv_seen |= blk_ready;
         @(posedge clk);
         @(negedge clk);
      end
      chk("bp_blk_ready", sv_seen, 1'b0);
      chk("bp_no_xfer", xfers.size(), 0);
      send_block(st, 5'd16, 1'b0, 1'b1, 1'b0);
      finish_op(0, s1);
      if (xfers.size() == 2) chk("bp_len", xfers[1], 128'h80);

      // Abort in WAIT: one init pulse, back to IDLE, stray Y_valid ignored.
      start_op(rnd128());
      send_block(rnd128(), 5'd16, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      blk_valid = 1'b0; g_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1;
      chk("abort_g_init", g_init, 1'b1);
      chk("abort_busy_before", busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_idle", busy, 1'b0);
      chk("abort_init_once", g_init, 1'b0);
      sv_seen = 1'b0; yv_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         sv_seen |= s_valid;
         yv_seen |= g_Y_valid;
      end
      chk("abort_no_s_valid", sv_seen, 1'b0);
      chk("abort_stray_y", yv_seen, 1'b1);

      // Result hold with start pulsed while waiting for s_ready.
      start_op(rnd128());
      send_block(rnd128(), 5'd16, 1'b1, 1'b0, 1'b1);
      send_block(rnd128(), 5'd9, 1'b0, 1'b1, 1'b1);
      finish_op(10, s1);

      // Reset in the middle of an operation.
      start_op(rnd128());
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_gH", g_H, 128'd0);
      chk("midrst_g_init", g_init, 1'b0);
      rst_n = 1'b1;

      // Randomized messages.
      for (int op = 0; op < 15; op++) begin
         start_op(rnd128());
         nblk = $urandom_range(0, 5);
         na = $urandom_range(0, nblk);
         if (nblk == 0) begin
            send_block(rnd128(), 5'd0, 1'b0, 1'b1, 1'b1);
         end else begin
            for (int b = 0; b < nblk; b++) begin
               aad = (b < na) ^ ($urandom_range(0, 7) == 0);
               nb = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 16)) : 5'd16;
               send_block(rnd128(), nb, aad, (b == nblk - 1), 1'b1);
            end
         end
         finish_op(0, s1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
